// File: rtl/ahb_pkg.sv
// Shared AHB types and constants for the SRAM slave.
// Optional feature macro (used by ahb_sram_slave): AHB_SLV_WAIT_EN.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3,
        SIZE_16B   = 3'd4,
        SIZE_32B   = 3'd5,
        SIZE_64B   = 3'd6,
        SIZE_128B  = 3'd7
    } hsize_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        WAITS = 3'd2,
        ERR1  = 3'd3,
        ERR2  = 3'd4
    } slv_state_e;

    localparam hresp_e HRESP_OKAY  = RESP_OKAY;
    localparam hresp_e HRESP_ERROR = RESP_ERROR;

    // Little-endian byte-lane mask (up to 8 lanes) for a transfer of 2^size bytes at lane offset.
    function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] offset);
        return 8'(((16'd1 << (16'd1 << size)) - 16'd1) << offset);
    endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// DEPTH x DW register-array memory: byte-enable synchronous write, asynchronous read.
// Contents are deliberately not reset.
module ahb_slv_mem #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned LANES = DW / 8,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [LANES-1:0] be_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [DW-1:0]    rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Byte-lane write port
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < int'(LANES); b++) begin
            if (we_i && be_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Asynchronous read port
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave SRAM: address-phase latch, error check, response FSM and memory.
// Optional wait-state insertion is compiled in with AHB_SLV_WAIT_EN.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WAIT  = 1
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          hselect,
    input  logic [AW-1:0] haddr,
    input  logic          hwrite,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [DW-1:0] hwdata,
    output logic          hready,
    output logic [1:0]    hresp,
    output logic [DW-1:0] hrdata
);

    localparam int unsigned LANES     = DW / 8;
    localparam int unsigned LANE_W    = $clog2(LANES);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'(LANES);

`ifdef AHB_SLV_WAIT_EN
    localparam bit WAIT_ON = (WAIT != 0);
    logic [3:0] wcnt_q, wcnt_d;
`else
    // WAIT has no effect without the wait-state feature.
    localparam bit WAIT_ON = 1'b0 && (WAIT != 0);
`endif

    slv_state_e    state_q, state_d;
    logic          hready_q, hready_d;
    logic [1:0]    hresp_q, hresp_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [2:0]    size_q, size_d;

    logic              accept_c;
    logic              xfer_err_c;
    logic [LANE_W-1:0] align_mask_c;
    logic              we_c;
    logic [LANES-1:0]  be_c;
    logic [IDX_W-1:0]  word_c;
    logic [DW-1:0]     rdata_c;
    logic              unused_c;

    // Address phase qualification and transfer legality
    assign accept_c     = hselect & htrans[1] & hready_q;
    assign align_mask_c = LANE_W'((32'd1 << hsize) - 32'd1);
    assign xfer_err_c   = (64'(haddr) >= MEM_BYTES)
                        | (hsize > 3'(LANE_W))
                        | ((haddr[LANE_W-1:0] & align_mask_c) != '0);

    // Next-state, address-phase latch and registered response decode
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
`ifdef AHB_SLV_WAIT_EN
        wcnt_d  = wcnt_q;
`endif
        case (state_q)
            ERR1: state_d = ERR2;
`ifdef AHB_SLV_WAIT_EN
            WAITS: begin
                if (wcnt_q == 4'd1) begin
                    state_d = DATA;
                    wcnt_d  = 4'd0;
                end else begin
                    wcnt_d  = wcnt_q - 4'd1;
                end
            end
`endif
            default: begin
                // IDLE, DATA and ERR2 all complete this cycle, so a new transfer may pipeline in.
                state_d = IDLE;
                if (accept_c) begin
                    addr_d  = haddr;
                    write_d = hwrite;
                    size_d  = hsize;
                    if (xfer_err_c) begin
                        state_d = ERR1;
                    end else if (WAIT_ON) begin
                        state_d = WAITS;
`ifdef AHB_SLV_WAIT_EN
                        wcnt_d  = 4'(WAIT);
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
        endcase
        hready_d = !((state_d == ERR1) || (state_d == WAITS));
        hresp_d  = ((state_d == ERR1) || (state_d == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    // State, response and address-phase registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
        end else begin
            state_q  <= state_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
        end
    end

`ifdef AHB_SLV_WAIT_EN
    // Wait-state counter
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wcnt_q <= 4'd0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`endif

    // Write commits on the edge that ends a good write data phase
    assign we_c   = (state_q == DATA) & write_q;
    assign be_c   = LANES'(lane_mask(size_q, 3'(addr_q[LANE_W-1:0])));
    assign word_c = addr_q[LANE_W +: IDX_W];

    ahb_slv_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (HCLK),
        .we_i    (we_c),
        .be_i    (be_c),
        .waddr_i (word_c),
        .wdata_i (hwdata),
        .raddr_i (word_c),
        .rdata_o (rdata_c)
    );

    assign hready = hready_q;
    assign hresp  = hresp_q;
    assign hrdata = ((state_q == DATA) && !write_q) ? rdata_c : '0;

    // Burst type, BUSY/IDLE distinction and high address bits carry no meaning here
    assign unused_c = ^{hburst, htrans[0], addr_q};

endmodule
